omsp_dbg_mem_arb: RTL and testbench

- Arbitrates a single-port synchronous program/data memory between the CPU execution unit and the serial debug interface.
- The CPU has default priority. A starvation counter forces debug accesses through by stalling the CPU via cpu_wait.
- The block steers read data back to the requester and pulses a one-cycle acknowledge to the debug side. It sits between the core frontend/EU memory port and the RAM/ROM macro.

---
 rtl/omsp_dbg_mem_arb.sv | 192 +++++++++++++++++++
 tb/tb_omsp_dbg_mem_arb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/omsp_dbg_mem_arb.sv
// -----------------------------------------------------------------------------
// omsp_dbg_mem_arb
//
// Shares one single-port synchronous program/data memory between the CPU
// execution unit and the serial debug interface.
//
// The CPU normally wins. A pending debug request that keeps losing is counted
// in a starvation counter. Once the count reaches STARVE_MAX, the debug access
// is forced through and the CPU is stalled with cpu_wait. Read data is
// returned to whichever side asked for it, and the debug side gets a
// one-cycle acknowledge.
//
// Parameters
//   AWIDTH      word-address width of every address port
//   STARVE_MAX  cycles a pending debug request may lose before it is forced
//               (0 = debug always wins, legal range 0..15)
//
// Ports
//   mclk, reset_n         clock, asynchronous active-low reset
//   cpu_req/wen/addr/din  CPU access request (one cycle per access)
//   cpu_dout              CPU read data, straight from the memory
//   cpu_wait              CPU lost this cycle and must hold its request
//   dbg_req/wen/addr/din  debug request, level-held until dbg_ack
//   dbg_dout              debug read data, held between debug reads
//   dbg_ack               one-cycle pulse, debug access complete
//   mem_cen/wen/addr/din  memory macro controls (active-low enables)
//   mem_dout              memory read data, valid one cycle after mem_cen low
// -----------------------------------------------------------------------------
module omsp_dbg_mem_arb #(
    parameter int unsigned AWIDTH     = 15,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              mclk,
    input  logic              reset_n,

    input  logic              cpu_req,
    input  logic [1:0]        cpu_wen,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [15:0]       cpu_din,
    output logic [15:0]       cpu_dout,
    output logic              cpu_wait,

    input  logic              dbg_req,
    input  logic [1:0]        dbg_wen,
    input  logic [AWIDTH-1:0] dbg_addr,
    input  logic [15:0]       dbg_din,
    output logic [15:0]       dbg_dout,
    output logic              dbg_ack,

    output logic              mem_cen,
    output logic [1:0]        mem_wen,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [15:0]       mem_din,
    input  logic [15:0]       mem_dout
);

    // Counter width is fixed at four bits, so the limit fits STARVE_MAX <= 15.
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [3:0]        r_starve_cnt;  // consecutive losses of a pending debug request
    logic              r_dbg_pend;    // debug access granted last cycle (ack cycle)
    logic              r_dbg_rd;      // the pending debug access is a read
    logic [15:0]       r_dbg_dout;    // last completed debug read data
    logic [AWIDTH-1:0] r_mem_addr;    // last address driven to the memory
    logic [15:0]       r_mem_din;     // last write data driven to the memory

    // ------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------
    logic              w_dbg_eligible;
    logic              w_starved;
    logic              w_grant_dbg;
    logic              w_grant_cpu;
    logic [1:0]        w_win_wen;
    logic [AWIDTH-1:0] w_win_addr;
    logic [15:0]       w_win_din;
    logic [3:0]        w_starve_nxt;
    logic              w_dout_bypass;

    // A debug request is ignored in its own ack cycle so it is not issued twice.
    assign w_dbg_eligible = dbg_req & ~r_dbg_pend;

    // With a zero limit the debug side is always considered starved; a plain
    // compare against zero would be constant, so it is split out here.
    generate
        if (STARVE_MAX == 0) begin : g_no_starve_wait
            assign w_starved = 1'b1;
        end else begin : g_starve_cmp
            assign w_starved = (r_starve_cnt >= STARVE_LIM);
        end
    endgenerate

    // Grants are gated by reset_n so every output shows its reset value
    // immediately while reset is asserted, even with requests still active.
    assign w_grant_dbg = reset_n & w_dbg_eligible & (~cpu_req | w_starved);
    assign w_grant_cpu = reset_n & cpu_req & ~w_grant_dbg;

    // Winner mux; with no winner the address and data buses hold their last value.
    always_comb begin
        w_win_wen  = 2'b00;
        w_win_addr = r_mem_addr;
        w_win_din  = r_mem_din;
        if (w_grant_dbg) begin
            w_win_wen  = dbg_wen;
            w_win_addr = dbg_addr;
            w_win_din  = dbg_din;
        end else if (w_grant_cpu) begin
            w_win_wen  = cpu_wen;
            w_win_addr = cpu_addr;
            w_win_din  = cpu_din;
        end else begin
            w_win_wen  = 2'b00;
            w_win_addr = r_mem_addr;
            w_win_din  = r_mem_din;
        end
    end

    // Starvation counter next value: clear, count a loss, or saturate.
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (w_grant_dbg || !dbg_req) begin
            w_starve_nxt = 4'd0;
        end else if (w_dbg_eligible && w_grant_cpu && !w_starved) begin
            w_starve_nxt = r_starve_cnt + 4'd1;
        end else begin
            w_starve_nxt = r_starve_cnt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_cen  = ~(w_grant_cpu | w_grant_dbg);
    assign mem_wen  = ~w_win_wen;
    assign mem_addr = w_win_addr;
    assign mem_din  = w_win_din;

    assign cpu_wait = cpu_req & w_grant_dbg;
    assign cpu_dout = mem_dout;

    assign dbg_ack  = r_dbg_pend;

    // Read data only arrives from the memory during the ack cycle, so it is
    // forwarded straight through then and captured for the following cycles.
    assign w_dout_bypass = r_dbg_pend & r_dbg_rd;
    assign dbg_dout      = w_dout_bypass ? mem_dout : r_dbg_dout;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // Debug completion tracking: pending flag, read flag and captured read data.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_dbg_pend <= 1'b0;
            r_dbg_rd   <= 1'b0;
            r_dbg_dout <= 16'h0000;
        end else begin
            r_dbg_pend <= w_grant_dbg;
            r_dbg_rd   <= w_grant_dbg & (dbg_wen == 2'b00);
            if (w_dout_bypass) begin
                r_dbg_dout <= mem_dout;
            end else begin
                r_dbg_dout <= r_dbg_dout;
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= 4'd0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
        end
    end

    // Memory bus hold registers, so idle cycles do not toggle address or data.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_addr <= '0;
            r_mem_din  <= 16'h0000;
        end else begin
            r_mem_addr <= w_win_addr;
            r_mem_din  <= w_win_din;
        end
    end

endmodule

// File: tb/tb_omsp_dbg_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_omsp_dbg_mem_arb
//
// Directed bench for the debug/CPU memory arbiter. Instance u_a uses
// STARVE_MAX=4 and drives a small memory model; instance u_z uses
// STARVE_MAX=0 and shares the CPU and debug data inputs but has its own
// debug request. Expected debug read data is queued when a debug access is
// issued and popped when u_a acknowledges it.
// -----------------------------------------------------------------------------
module tb_omsp_dbg_mem_arb;

    localparam int AW = 15;

    logic          mclk = 1'b0;
    logic          reset_n;
    logic          cpu_req;
    logic [1:0]    cpu_wen;
    logic [AW-1:0] cpu_addr;
    logic [15:0]   cpu_din;
    logic          dbg_req;
    logic          z_dbg_req;
    logic [1:0]    dbg_wen;
    logic [AW-1:0] dbg_addr;
    logic [15:0]   dbg_din;
    logic [15:0]   mem_dout;

    logic [15:0]   a_cpu_dout, z_cpu_dout;
    logic          a_cpu_wait, z_cpu_wait;
    logic [15:0]   a_dbg_dout, z_dbg_dout;
    logic          a_dbg_ack,  z_dbg_ack;
    logic          a_mem_cen,  z_mem_cen;
    logic [1:0]    a_mem_wen,  z_mem_wen;
    logic [AW-1:0] a_mem_addr, z_mem_addr;
    logic [15:0]   a_mem_din,  z_mem_din;

    omsp_dbg_mem_arb #(.AWIDTH(AW), .STARVE_MAX(4)) u_a (
        .mclk(mclk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(a_cpu_dout), .cpu_wait(a_cpu_wait),
        .dbg_req(dbg_req), .dbg_wen(dbg_wen), .dbg_addr(dbg_addr), .dbg_din(dbg_din),
        .dbg_dout(a_dbg_dout), .dbg_ack(a_dbg_ack),
        .mem_cen(a_mem_cen), .mem_wen(a_mem_wen), .mem_addr(a_mem_addr), .mem_din(a_mem_din),
        .mem_dout(mem_dout)
    );

    omsp_dbg_mem_arb #(.AWIDTH(AW), .STARVE_MAX(0)) u_z (
        .mclk(mclk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(z_cpu_dout), .cpu_wait(z_cpu_wait),
        .dbg_req(z_dbg_req), .dbg_wen(dbg_wen), .dbg_addr(dbg_addr), .dbg_din(dbg_din),
        .dbg_dout(z_dbg_dout), .dbg_ack(z_dbg_ack),
        .mem_cen(z_mem_cen), .mem_wen(z_mem_wen), .mem_addr(z_mem_addr), .mem_din(z_mem_din),
        .mem_dout(mem_dout)
    );

    always #5 mclk = ~mclk;

    // Memory model on u_a's bus: 64 words, word i preset to 0xA000+i, word 0x10 = 0xBEEF.
    logic [15:0] mem [0:63];
    always @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= 16'hA000 + 16'(i);
            mem[16]  <= 16'hBEEF;
            mem_dout <= 16'h0000;
        end else if (!a_mem_cen) begin
            mem_dout <= mem[a_mem_addr[5:0]];
            if (!a_mem_wen[0]) mem[a_mem_addr[5:0]][7:0]  <= a_mem_din[7:0];
            if (!a_mem_wen[1]) mem[a_mem_addr[5:0]][15:8] <= a_mem_din[15:8];
        end
    end

    logic [15:0] sb_q [$];
    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven on the falling edge, away from the active edge.
    task automatic cyc();
        @(negedge mclk);
    endtask

    // Let the drive settle, then check any debug acknowledge against the scoreboard.
    task automatic settle();
        #1;
        if (a_dbg_ack === 1'b1) begin
            if (sb_q.size() == 0) chk("ack_without_request", {31'd0, a_dbg_ack}, 32'd0);
            else                  chk("dbg_dout_at_ack", {16'd0, a_dbg_dout}, {16'd0, sb_q.pop_front()});
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cen"},  {31'd0, a_mem_cen},  32'd1);
        chk({tag, "_wen"},  {30'd0, a_mem_wen},  32'd3);
        chk({tag, "_addr"}, {17'd0, a_mem_addr}, 32'd0);
        chk({tag, "_din"},  {16'd0, a_mem_din},  32'd0);
        chk({tag, "_wait"}, {31'd0, a_cpu_wait}, 32'd0);
        chk({tag, "_ack"},  {31'd0, a_dbg_ack},  32'd0);
        chk({tag, "_dout"}, {16'd0, a_dbg_dout}, 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        cpu_req   = 1'b0; cpu_wen = 2'b00; cpu_addr = '0; cpu_din = 16'h0000;
        dbg_req   = 1'b0; z_dbg_req = 1'b0; dbg_wen = 2'b00; dbg_addr = '0; dbg_din = 16'h0000;

        // Reset state
        cyc(); settle();
        chk_reset_vals("rst");
        chk("rst_starve", {28'd0, u_a.r_starve_cnt}, 32'd0);
        cyc(); reset_n = 1'b1; settle();

        // Debug read alone
        cyc(); dbg_req = 1'b1; dbg_wen = 2'b00; dbg_addr = 15'h0010; sb_q.push_back(16'hBEEF); settle();
        chk("rd_cen",   {31'd0, a_mem_cen},  32'd0);
        chk("rd_addr",  {17'd0, a_mem_addr}, 32'h10);
        chk("rd_wen",   {30'd0, a_mem_wen},  32'd3);
        chk("rd_wait",  {31'd0, a_cpu_wait}, 32'd0);
        chk("rd_noack", {31'd0, a_dbg_ack},  32'd0);
        cyc(); settle();
        chk("rd_ack",    {31'd0, a_dbg_ack}, 32'd1);
        chk("rd_ackcen", {31'd0, a_mem_cen}, 32'd1);
        cyc(); dbg_req = 1'b0; settle();
        chk("rd_single", {31'd0, a_dbg_ack},  32'd0);
        chk("rd_hold1",  {16'd0, a_dbg_dout}, 32'hBEEF);
        cyc(); cpu_req = 1'b1; cpu_addr = 15'h0020; settle();
        chk("cpu_cen", {31'd0, a_mem_cen}, 32'd0);
        cyc(); cpu_req = 1'b0; settle();
        chk("cpu_dout", {16'd0, a_cpu_dout}, 32'hA020);
        chk("rd_hold2", {16'd0, a_dbg_dout}, 32'hBEEF);

        // Starvation with STARVE_MAX=4
        for (int k = 0; k < 4; k++) begin
            cyc();
            cpu_req = 1'b1; cpu_wen = 2'b00; cpu_addr = 15'h0020 + 15'(k);
            dbg_req = 1'b1; dbg_wen = 2'b00; dbg_addr = 15'h0012;
            if (k == 0) sb_q.push_back(16'hA012);
            settle();
            chk("stv_wait", {31'd0, a_cpu_wait},  32'd0);
            chk("stv_addr", {17'd0, a_mem_addr},  32'h20 + 32'(k));
            chk("stv_cnt",  {28'd0, u_a.r_starve_cnt}, 32'(k));
        end
        cyc(); cpu_addr = 15'h0030; settle();
        chk("stv_force_wait", {31'd0, a_cpu_wait}, 32'd1);
        chk("stv_force_addr", {17'd0, a_mem_addr}, 32'h12);
        chk("stv_force_cen",  {31'd0, a_mem_cen},  32'd0);
        cyc(); settle();
        chk("stv_ack",      {31'd0, a_dbg_ack},  32'd1);
        chk("stv_ack_wait", {31'd0, a_cpu_wait}, 32'd0);
        chk("stv_ack_addr", {17'd0, a_mem_addr}, 32'h30);
        chk("stv_ack_cnt",  {28'd0, u_a.r_starve_cnt}, 32'd0);
        cyc(); cpu_req = 1'b0; dbg_req = 1'b0; settle();
        chk("stv_cpu_dout", {16'd0, a_cpu_dout}, 32'hA030);
        chk("stv_dout",     {16'd0, a_dbg_dout}, 32'hA012);

        // STARVE_MAX=0: debug write wins over a simultaneous CPU read
        cyc();
        cpu_req = 1'b1; cpu_wen = 2'b00; cpu_addr = 15'h0031;
        z_dbg_req = 1'b1; dbg_wen = 2'b11; dbg_din = 16'h1234; dbg_addr = 15'h0200;
        settle();
        chk("z_cen",  {31'd0, z_mem_cen},  32'd0);
        chk("z_wen",  {30'd0, z_mem_wen},  32'd0);
        chk("z_din",  {16'd0, z_mem_din},  32'h1234);
        chk("z_addr", {17'd0, z_mem_addr}, 32'h200);
        chk("z_wait", {31'd0, z_cpu_wait}, 32'd1);
        cyc(); settle();
        chk("z_ack",      {31'd0, z_dbg_ack},  32'd1);
        chk("z_cpu_wait", {31'd0, z_cpu_wait}, 32'd0);
        chk("z_cpu_cen",  {31'd0, z_mem_cen},  32'd0);
        chk("z_cpu_addr", {17'd0, z_mem_addr}, 32'h31);
        chk("z_dout",     {16'd0, z_dbg_dout}, 32'd0);
        cyc(); cpu_req = 1'b0; z_dbg_req = 1'b0; dbg_wen = 2'b00; settle();
        chk("z_single", {31'd0, z_dbg_ack}, 32'd0);

        // Byte write of the high byte, then read it back
        cyc(); dbg_req = 1'b1; dbg_wen = 2'b10; dbg_din = 16'hAB00; dbg_addr = 15'h0010;
        sb_q.push_back(16'hA012); settle();
        chk("bw_wen", {30'd0, a_mem_wen}, 32'd1);
        chk("bw_din", {16'd0, a_mem_din}, 32'hAB00);
        chk("bw_cen", {31'd0, a_mem_cen}, 32'd0);
        cyc(); settle();
        chk("bw_ack", {31'd0, a_dbg_ack}, 32'd1);
        cyc(); dbg_req = 1'b0; dbg_wen = 2'b00; settle();
        chk("bw_dout", {16'd0, a_dbg_dout}, 32'hA012);
        cyc(); dbg_req = 1'b1; dbg_addr = 15'h0010; sb_q.push_back(16'hABEF); settle();
        cyc(); settle();
        chk("rb_ack", {31'd0, a_dbg_ack}, 32'd1);
        cyc(); dbg_req = 1'b0; settle();

        // Back-to-back debug reads: grants in cycles 0 and 2 only
        cyc(); dbg_req = 1'b1; dbg_addr = 15'h0011;
        sb_q.push_back(16'hA011); sb_q.push_back(16'hA011); settle();
        chk("b2b_c0_cen", {31'd0, a_mem_cen}, 32'd0);
        cyc(); settle();
        chk("b2b_c1_ack", {31'd0, a_dbg_ack}, 32'd1);
        chk("b2b_c1_cen", {31'd0, a_mem_cen}, 32'd1);
        cyc(); settle();
        chk("b2b_c2_cen", {31'd0, a_mem_cen}, 32'd0);
        chk("b2b_c2_ack", {31'd0, a_dbg_ack}, 32'd0);
        cyc(); settle();
        chk("b2b_c3_ack", {31'd0, a_dbg_ack}, 32'd1);
        chk("b2b_c3_cen", {31'd0, a_mem_cen}, 32'd1);
        cyc(); dbg_req = 1'b0; settle();
        chk("b2b_c4_ack", {31'd0, a_dbg_ack}, 32'd0);
        chk("b2b_c4_cen", {31'd0, a_mem_cen}, 32'd1);

        // Reset in the cycle after a debug grant discards the acknowledge
        cyc(); dbg_req = 1'b1; dbg_addr = 15'h0013; sb_q.push_back(16'hA013); settle();
        chk("mr_grant_cen", {31'd0, a_mem_cen}, 32'd0);
        cyc(); reset_n = 1'b0; cpu_req = 1'b1; sb_q.delete(); settle();
        chk_reset_vals("mr");
        cyc(); settle();
        chk("mr_hold_ack", {31'd0, a_dbg_ack}, 32'd0);
        cyc(); reset_n = 1'b1; cpu_req = 1'b0; dbg_req = 1'b0; settle();
        chk("mr_rel_cen", {31'd0, a_mem_cen}, 32'd1);
        chk("mr_rel_ack", {31'd0, a_dbg_ack}, 32'd0);
        cyc(); settle();
        chk("mr_idle_cen", {31'd0, a_mem_cen}, 32'd1);
        chk("mr_idle_ack", {31'd0, a_dbg_ack}, 32'd0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
